// File: rtl/mem_read_burst.sv
// Single-outstanding AXI read-burst master with a one-register response stage.
// Define MEM_READ_BURST_ERR_EN to flag RRESP errors and RLAST misplacement on rsp_err.
module mem_read_burst #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int LEN_W  = 8
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last,
  output logic              rsp_err,
  output logic              ARVALID,
  input  logic              ARREADY,
  output logic [ADDR_W-1:0] ARADDR,
  output logic [LEN_W-1:0]  ARLEN,
  output logic [2:0]        ARSIZE,
  output logic [1:0]        ARBURST,
  output logic [2:0]        ARPROT,
  input  logic              RVALID,
  output logic              RREADY,
  input  logic [DATA_W-1:0] RDATA,
  input  logic              RLAST,
  input  logic [1:0]        RRESP
);

  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2} state_t;

  localparam logic [2:0] AXSIZE = 3'($clog2(DATA_W / 8));

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] araddr_reg;
  logic [LEN_W-1:0]  arlen_reg;
  logic [LEN_W-1:0]  cnt_reg;
  logic              rsp_valid_reg;
  logic [DATA_W-1:0] rsp_data_reg;
  logic              rsp_last_reg;
  logic              stage_free;
  logic              req_fire;
  logic              r_fire;

  // The response register can take a new beat if empty or being drained this cycle.
  assign stage_free = !rsp_valid_reg || rsp_ready;
  assign req_fire   = req_valid && req_ready;
  assign r_fire     = RVALID && RREADY;

  always_comb begin
    state_next = state_reg;
    req_ready  = 1'b0;
    ARVALID    = 1'b0;
    RREADY     = 1'b0;
    case (state_reg)
      IDLE: begin
        req_ready = ARESETn;
        if (req_valid && ARESETn) state_next = ADDR;
      end
      ADDR: begin
        ARVALID = 1'b1;
        if (ARREADY) state_next = DATA;
      end
      DATA: begin
        RREADY = stage_free;
        if (RVALID && stage_free && RLAST) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_reg     <= IDLE;
      araddr_reg    <= '0;
      arlen_reg     <= '0;
      cnt_reg       <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_data_reg  <= '0;
      rsp_last_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (req_fire) begin
        araddr_reg <= req_addr;
        arlen_reg  <= req_len;
        cnt_reg    <= '0;
      end else if (r_fire) begin
        cnt_reg <= cnt_reg + LEN_W'(1);
      end
      if (r_fire) begin
        rsp_valid_reg <= 1'b1;
        rsp_data_reg  <= RDATA;
        rsp_last_reg  <= RLAST;
      end else if (rsp_ready) begin
        rsp_valid_reg <= 1'b0;
      end
    end
  end

`ifdef MEM_READ_BURST_ERR_EN
  logic err_sticky_reg;
  logic rsp_err_reg;
  logic beat_err;

  // RLAST must land exactly on the beat whose index equals the latched length.
  assign beat_err = (RRESP != 2'b00) || (RLAST != (cnt_reg == arlen_reg));

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      err_sticky_reg <= 1'b0;
      rsp_err_reg    <= 1'b0;
    end else begin
      if (req_fire) begin
        err_sticky_reg <= 1'b0;
      end else if (r_fire) begin
        err_sticky_reg <= err_sticky_reg | beat_err;
      end
      if (r_fire) rsp_err_reg <= err_sticky_reg | beat_err;
    end
  end

  assign rsp_err = rsp_err_reg;
`else
  logic unused_rresp;
  assign unused_rresp = ^RRESP;
  assign rsp_err      = 1'b0;
`endif

  assign rsp_valid = rsp_valid_reg;
  assign rsp_data  = rsp_data_reg;
  assign rsp_last  = rsp_last_reg;
  assign ARADDR    = araddr_reg;
  assign ARLEN     = arlen_reg;
  assign ARSIZE    = AXSIZE;
  assign ARBURST   = 2'b01;
  assign ARPROT    = 3'b111;

endmodule

// File: tb/tb_mem_read_burst.sv
// Randomised bench for mem_read_burst: an AXI slave model plus a transaction-level
// scoreboard of expected handshakes and response beats.
`timescale 1ns/1ps
module tb_mem_read_burst;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;
  localparam int LEN_W  = 8;

  logic              ACLK = 1'b0;
  logic              ARESETn;
  logic              req_valid, req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [LEN_W-1:0]  req_len;
  logic              rsp_valid, rsp_ready, rsp_last, rsp_err;
  logic [DATA_W-1:0] rsp_data;
  logic              ARVALID, ARREADY;
  logic [ADDR_W-1:0] ARADDR;
  logic [LEN_W-1:0]  ARLEN;
  logic [2:0]        ARSIZE, ARPROT;
  logic [1:0]        ARBURST;
  logic              RVALID, RREADY, RLAST;
  logic [DATA_W-1:0] RDATA;
  logic [1:0]        RRESP;

  always #5 ACLK = ~ACLK;

  mem_read_burst #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_last(rsp_last), .rsp_err(rsp_err),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARLEN(ARLEN),
    .ARSIZE(ARSIZE), .ARBURST(ARBURST), .ARPROT(ARPROT),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RLAST(RLAST), .RRESP(RRESP)
  );

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
    int                lastpos;
    int                badidx;
    int                ar_delay;
  } req_t;
  typedef struct {
    logic [DATA_W-1:0] data;
    logic              last;
    logic [1:0]        resp;
  } beat_t;
  typedef struct {
    logic [DATA_W-1:0] data;
    logic              last;
    logic              err;
  } rsp_t;

  req_t  reqq[$];
  beat_t beatq[$];
  rsp_t  rspq[$];
  bit    rdyq[$];

  int   checks = 0;
  int   errors = 0;
  int   phase = 0;          // 0: waiting for request, 1: address phase, 2: data phase
  req_t cur;
  int   ar_cnt = 0;
  int   beat_idx = 0;
  bit   sticky = 0;
  int   gap = 0;
  int   gap_max = 0;
  int   rv_pct = 100;
  int   rr_pct = 100;
  bit   rv_pending = 0;
  bit   rst_armed = 0;
  int   rsp_count = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic add_req(input logic [ADDR_W-1:0] a, input int len, input int lastpos,
                         input int badidx, input int ar_delay);
    req_t r;
    r.addr = a; r.len = LEN_W'(len); r.lastpos = lastpos; r.badidx = badidx; r.ar_delay = ar_delay;
    reqq.push_back(r);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_arvalid"}, 64'(ARVALID), 64'(0));
    check({tag, "_araddr"}, 64'(ARADDR), 64'(0));
    check({tag, "_arlen"}, 64'(ARLEN), 64'(0));
    check({tag, "_rready"}, 64'(RREADY), 64'(0));
    check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
    check({tag, "_rsp_data"}, rsp_data, 64'(0));
    check({tag, "_rsp_last"}, 64'(rsp_last), 64'(0));
    check({tag, "_rsp_err"}, 64'(rsp_err), 64'(0));
    check({tag, "_req_ready"}, 64'(req_ready), 64'(0));
  endtask

  task automatic do_reset();
    ARESETn = 1'b0; req_valid = 1'b0; RVALID = 1'b0;
    #1;
    check("req_ready_in_reset", 64'(req_ready), 64'(0));
    @(posedge ACLK); #1;
    check_all_zero("midburst_rst");
    ARESETn = 1'b1;
    phase = 0; beatq.delete(); rspq.delete(); rdyq.delete();
    rv_pending = 0; rst_armed = 0; gap = 0;
    #1;
    check("req_ready_after_rst", 64'(req_ready), 64'(1));
    $display("reset applied mid-burst, model flushed");
    @(posedge ACLK); #1;
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance the model.
  task automatic step();
    beat_t b;
    rsp_t  r;
    bit    req_fire, ar_fire, r_fire, rsp_fire, exp_rready, ebeat, eerr;
    if (rst_armed && phase == 2 && beat_idx == 2) begin
      do_reset();
      return;
    end
    req_valid = (reqq.size() > 0) && (gap == 0);
    if (reqq.size() > 0) begin
      req_addr = reqq[0].addr; req_len = reqq[0].len;
    end else begin
      req_addr = ADDR_W'($urandom); req_len = LEN_W'($urandom);
    end
    ARREADY = (phase == 1) ? (ar_cnt >= cur.ar_delay) : 1'($urandom_range(1));
    if (!rv_pending) begin
      if (beatq.size() > 0 && $urandom_range(99) < rv_pct) begin
        RVALID = 1'b1; RDATA = beatq[0].data; RLAST = beatq[0].last; RRESP = beatq[0].resp;
        rv_pending = 1;
      end else begin
        RVALID = 1'b0; RDATA = '0; RLAST = 1'($urandom_range(1)); RRESP = 2'($urandom_range(3));
      end
    end
    if (phase == 2 && rdyq.size() > 0) rsp_ready = rdyq.pop_front();
    else rsp_ready = ($urandom_range(99) < rr_pct);
    #1;
    exp_rready = (phase == 2) && (rspq.size() == 0 || rsp_ready);
    check("req_ready", 64'(req_ready), 64'(phase == 0));
    check("arvalid", 64'(ARVALID), 64'(phase == 1));
    if (phase == 1) begin
      check("araddr", 64'(ARADDR), 64'(cur.addr));
      check("arlen", 64'(ARLEN), 64'(cur.len));
      check("arsize", 64'(ARSIZE), 64'(3));
      check("arburst", 64'(ARBURST), 64'(1));
      check("arprot", 64'(ARPROT), 64'(7));
    end
    check("rready", 64'(RREADY), 64'(exp_rready));
    check("rsp_valid", 64'(rsp_valid), 64'(rspq.size() > 0));
    if (rspq.size() > 0) begin
      check("rsp_data", rsp_data, rspq[0].data);
      check("rsp_last", 64'(rsp_last), 64'(rspq[0].last));
      check("rsp_err", 64'(rsp_err), 64'(rspq[0].err));
    end
    req_fire = req_valid && (phase == 0);
    ar_fire  = (phase == 1) && ARREADY;
    r_fire   = RVALID && exp_rready;
    rsp_fire = (rspq.size() > 0) && rsp_ready;

    if (phase == 1 && !ar_fire) ar_cnt++;
    if (!req_fire && gap > 0) gap--;
    if (rsp_fire) begin
      r = rspq.pop_front();
      rsp_count++;
      $display("rsp beat data=%h last=%0b err=%0b", r.data, r.last, r.err);
    end
    if (r_fire) begin
      b = beatq.pop_front();
      rv_pending = 0;
      ebeat = (b.resp != 2'b00) || (b.last != ((beat_idx % (1 << LEN_W)) == int'(cur.len)));
`ifdef MEM_READ_BURST_ERR_EN
      eerr = sticky || ebeat;
      sticky = eerr;
`else
      eerr = 1'b0 & ebeat;
`endif
      r.data = b.data; r.last = b.last; r.err = eerr;
      rspq.push_back(r);
      beat_idx++;
      if (b.last) phase = 0;
    end
    if (ar_fire) begin
      phase = 2;
      for (int i = 0; i <= cur.lastpos; i++) begin
        b.data = {$urandom, $urandom};
        b.last = (i == cur.lastpos);
        b.resp = (i == cur.badidx) ? 2'b10 : 2'b00;
        beatq.push_back(b);
      end
    end
    if (req_fire) begin
      cur = reqq.pop_front();
      $display("req accepted addr=%h len=%0d", cur.addr, cur.len);
      phase = 1; ar_cnt = 0; beat_idx = 0; sticky = 0;
      gap = $urandom_range(gap_max);
    end
    @(posedge ACLK); #1;
  endtask

  task automatic run(input int budget);
    int n;
    n = 0;
    while ((reqq.size() > 0 || phase != 0 || rspq.size() > 0) && n < budget) begin
      step();
      n++;
    end
    check("drain_in_budget", 64'(n < budget), 64'(1));
  endtask

  initial begin
    int len, lastpos, badidx, total;
    ARESETn = 1'b0; req_valid = 1'b0; req_addr = '0; req_len = '0; rsp_ready = 1'b0;
    ARREADY = 1'b0; RVALID = 1'b0; RDATA = '0; RLAST = 1'b0; RRESP = 2'b00;
    repeat (2) @(posedge ACLK);
    #1;
    check_all_zero("reset");
    ARESETn = 1'b1;
    @(posedge ACLK); #1;

    // Basic 4-beat burst, everything ready
    rsp_count = 0;
    add_req(32'h8000_0000, 3, 3, -1, 0);
    run(100);
    check("basic_beats", 64'(rsp_count), 64'(4));

    // Address channel stalled
    rsp_count = 0;
    add_req(32'h1234_5678, 3, 3, -1, 5);
    run(100);
    check("arstall_beats", 64'(rsp_count), 64'(4));

    // Response back-pressure 1,0,0,1
    rsp_count = 0;
    rdyq = '{1'b1, 1'b0, 1'b0, 1'b1};
    add_req(32'h0000_1000, 3, 3, -1, 0);
    run(100);
    check("stall_beats", 64'(rsp_count), 64'(4));

    // Back-to-back single-beat bursts
    rsp_count = 0;
    add_req(32'h0000_2000, 0, 0, -1, 0);
    add_req(32'h0000_2040, 0, 0, -1, 0);
    run(100);
    check("len0_beats", 64'(rsp_count), 64'(2));

    // Reset during beat 2 of 4, then a clean burst afterwards
    rst_armed = 1;
    add_req(32'h0000_3000, 3, 3, -1, 0);
    run(100);
    rsp_count = 0;
    add_req(32'h0000_4000, 1, 1, -1, 0);
    run(100);
    check("post_rst_beats", 64'(rsp_count), 64'(2));

    // Error cases: bad RRESP on beat 1, early RLAST, late RLAST
    rsp_count = 0;
    add_req(32'h0000_5000, 3, 3, 1, 0);
    add_req(32'h0000_6000, 3, 2, -1, 0);
    add_req(32'h0000_7000, 1, 3, -1, 1);
    run(200);
    check("err_beats", 64'(rsp_count), 64'(4 + 3 + 4));

    // Full-length burst exercises counter wrap
    rsp_count = 0;
    rv_pct = 80; rr_pct = 80;
    add_req(32'h0001_0000, 255, 255, -1, 2);
    run(2000);
    check("maxlen_beats", 64'(rsp_count), 64'(256));

    // Randomised traffic
    rsp_count = 0; total = 0;
    for (int k = 0; k < 60; k++) begin
      len = $urandom_range(7);
      lastpos = len;
      badidx = -1;
      if ($urandom_range(9) == 0) lastpos = $urandom_range(len + 2);
      if ($urandom_range(9) == 0) badidx = $urandom_range(lastpos);
      total += lastpos + 1;
      add_req({$urandom} & 32'hFFFF_FFF8, len, lastpos, badidx, $urandom_range(4));
    end
    rv_pct = 60; rr_pct = 60; gap_max = 3;
    run(5000);
    check("random_beats", 64'(rsp_count), 64'(total));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
